l2_mem_responder: RTL
=====================

# l2_mem_responder

Memory-side responder for the L2 data cache's refill and write-back interfaces. Accepts line refill requests and streams the line back one word per cycle on `mem_refill_valid`/`mem_refill_data`. Accepts full-line write-backs and acknowledges each with a single-cycle `writeback_done`. Holds the backing store as an internal word array with a fixed, parameterised access latency, and sits between the L2 cache and the (future) external memory port.

## Interface
- `DATA_LENGTH`, 32, word width in bits (multiple of 8).
- `LINE_SIZE`, 64, line size in bytes; `WORDS_PER_LINE = LINE_SIZE/(DATA_LENGTH/8)`.
- `MEM_DEPTH_WORDS`, 16384, backing-store depth in words (power of 2, multiple of `WORDS_PER_LINE`).
- `MEM_LATENCY`, 4, access-latency cycles inserted before every refill stream or write-back (≥1).

Ports:
- `clk`  in  1  clock; everything samples on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `refill_req`  in  1  single-cycle pulse requesting a line refill.
- `refill_addr`  in  32  refill byte address, sampled with `refill_req`.
- `mem_refill_valid`  out  1  refill word valid.
- `mem_refill_data`  out  DATA_LENGTH  refill word, word 0 of the line first.
- `writeback_req`  in  1  level; held high by the L2 until it samples `writeback_done`.
- `writeback_addr`  in  32  write-back byte address, valid while `writeback_req` is high.
- `writeback_data`  in  LINE_SIZE*8  line data; word w is bits `[(w+1)*DATA_LENGTH-1 : w*DATA_LENGTH]`.
- `writeback_done`  out  1  one-cycle acknowledge.
- `busy`  out  1  high in any state other than IDLE.
- `refill_overrun`  out  1  sticky error flag; only reset clears it.

## Operation
- **Address decode:** line index = `addr[31:log2(LINE_SIZE)]`; byte and word offset bits are ignored.
  - Word address = `(line_index*WORDS_PER_LINE + w) mod MEM_DEPTH_WORDS`, so out-of-range addresses alias by wrap-around.
- **FSM states:** IDLE, WB_LAT, WB_WRITE, WB_DONE, WB_RELEASE, RF_LAT, RF_STREAM.
- **IDLE arbitration:** if `writeback_req` is high, go to WB_LAT.
  - Otherwise, if `refill_req` is high or a refill is pending, go to RF_LAT.
  - Write-back wins over refill so that a dirty victim lands in memory before a refill of the same line.
- **Write-back capture:** on entry, latch `writeback_addr` and `writeback_data` into a line buffer.
- **WB_LAT:** count `MEM_LATENCY` cycles, then go to WB_WRITE.
- **WB_WRITE:** write one buffered word per cycle, word 0 to `WORDS_PER_LINE-1`, then go to WB_DONE.
- **WB_DONE:** assert `writeback_done` for exactly one cycle, then go to WB_RELEASE.
- **WB_RELEASE:** wait for `writeback_req` to go low, then go to IDLE. This prevents a stale held request from re-triggering.
- **Refill capture:** latch the line base. RF_LAT counts `MEM_LATENCY` cycles, then goes to RF_STREAM.
- **RF_STREAM:** drive `mem_refill_valid=1` with consecutive words for `WORDS_PER_LINE` back-to-back cycles, with no gaps and no backpressure, then go to IDLE.
- **Pending refill:** a `refill_req` pulse that arrives in any non-IDLE state is stored in a one-deep pending register (flag plus address) and served in order.
  - A further pulse while the register is already full sets `refill_overrun` and is dropped.
  - A pulse in the same cycle the pending entry is consumed in IDLE is stored, not dropped.
- **Backing store:** not reset; contents are undefined until written.
- **Reset:** reset in mid-operation aborts immediately and returns the FSM to IDLE.
  - Words already written by an aborted write-back remain in memory.
  - The pending register is cleared.

## Timing
- **Reset values:** `mem_refill_valid=0`, `mem_refill_data=0`, `writeback_done=0`, `busy=0`, `refill_overrun=0`.
- **`mem_refill_data` outside valid cycles:** 0 whenever `mem_refill_valid` is low.
- **Refill:** with `refill_req` sampled in IDLE at cycle T, words appear at cycles T+MEM_LATENCY+1 through T+MEM_LATENCY+WORDS_PER_LINE. With defaults that is T+5 to T+20.
- **Write-back:** with `writeback_req` first sampled in IDLE at cycle T, `writeback_done` is high at cycle T+MEM_LATENCY+WORDS_PER_LINE+1 (T+21 with defaults).
- **Write visibility:** a word written at cycle k is visible to any refill read at cycle k+1 or later.
- **Throughput:** a pending refill leaves IDLE at the earliest one cycle after the previous operation returns to IDLE.

## Test plan
- **Write-back then refill:** write back line `0x0000_0040` with words `0x1000+i` at T=0, then pulse `refill_req` for the same address after `writeback_done`.
  - Required: `writeback_done` at T=21, one cycle wide.
  - Required: refill streams `0x1000`…`0x100F` on 16 consecutive cycles starting 5 cycles after the request.
- **Simultaneous requests:** assert `writeback_req` (line `0x80`, data `0xA0+i`) and `refill_req` (line `0x80`) in the same cycle.
  - Required: write-back completes first; the refill returns `0xA0`…`0xAF`; `refill_overrun` stays 0.
- **Pending and overrun:** during a refill stream, pulse `refill_req` once (line `0x40`), then pulse it again (line `0x80`).
  - Required: the line `0x40` refill is served after the current stream; `refill_overrun` goes to 1 and stays 1.
- **Wrap and offset:** write back `0x0001_0040` (aliases `0x40` at 16384 words), then refill `0x0000_0047`.
  - Required: the aliased data is returned; offset bits are ignored.
- **Reset mid-stream:** assert `rst` at the 8th refill word.
  - Required: `mem_refill_valid` drops to 0 asynchronously; `busy=0` after release; the next refill works normally.
- **Held write-back request:** hold `writeback_req` high for 3 cycles after `writeback_done`.
  - Required: no second write-back occurs; the FSM stays in WB_RELEASE until `writeback_req` falls.

Source files
------------

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 refill and write-back ports: fixed-latency
// backing store, one-deep pending refill slot, word-per-cycle line streaming.
`timescale 1ns/1ps
module l2_mem_responder #(
   parameter int DATA_LENGTH     = 32,
   parameter int LINE_SIZE       = 64,
   parameter int MEM_DEPTH_WORDS = 16384,
   parameter int MEM_LATENCY     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     refill_req,
   input  logic [31:0]              refill_addr,
   output logic                     mem_refill_valid,
   output logic [DATA_LENGTH-1:0]   mem_refill_data,
   input  logic                     writeback_req,
   input  logic [31:0]              writeback_addr,
   input  logic [LINE_SIZE*8-1:0]   writeback_data,
   output logic                     writeback_done,
   output logic                     busy,
   output logic                     refill_overrun
);

   localparam int WORDS_PER_LINE = LINE_SIZE / (DATA_LENGTH / 8);
   localparam int LB             = $clog2(LINE_SIZE);
   localparam int WIDX_W         = $clog2(WORDS_PER_LINE);
   localparam int AW             = $clog2(MEM_DEPTH_WORDS);
   localparam int LINE_W         = AW - WIDX_W;
   localparam int CNT_W          = $clog2(MEM_LATENCY + 1);

   typedef enum logic [2:0] {
      IDLE, WB_LAT, WB_WRITE, WB_DONE, WB_RELEASE, RF_LAT, RF_STREAM
   } state_t;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [WIDX_W-1:0]        r_widx;
   logic [LINE_W-1:0]        r_rf_line;
   logic                     r_pend;
   logic [LINE_W-1:0]        r_pend_line;
   logic                     r_valid;
   logic [DATA_LENGTH-1:0]   r_data;
   logic                     r_done;
   logic                     r_overrun;
   logic [LINE_W-1:0]        r_wb_line;
   logic [LINE_SIZE*8-1:0]   r_wb_buf;
   logic [DATA_LENGTH-1:0]   r_mem [MEM_DEPTH_WORDS];

   logic [LINE_W-1:0]        w_rf_line;
   logic [LINE_W-1:0]        w_wb_line;
   logic                     w_consume;
   logic                     w_req_to_pend;
   logic                     w_unused;

   // Only the line-index bits that fit the store are kept; the rest alias away.
   assign w_rf_line = refill_addr[LB +: LINE_W];
   assign w_wb_line = writeback_addr[LB +: LINE_W];
   assign w_unused  = ^{refill_addr[LB-1:0], refill_addr[31:LB+LINE_W],
                        writeback_addr[LB-1:0], writeback_addr[31:LB+LINE_W]};

   // A new pulse goes to the pending slot unless IDLE serves it directly.
   assign w_consume     = (r_state == IDLE) && !writeback_req && r_pend;
   assign w_req_to_pend = refill_req && ((r_state != IDLE) || writeback_req || r_pend);

   assign mem_refill_valid = r_valid;
   assign mem_refill_data  = r_data;
   assign writeback_done   = r_done;
   assign refill_overrun   = r_overrun;
   assign busy             = (r_state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_widx      <= '0;
         r_rf_line   <= '0;
         r_pend      <= 1'b0;
         r_pend_line <= '0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_done  <= 1'b0;

         if (w_req_to_pend) begin
            if (r_pend && !w_consume) begin
               r_overrun <= 1'b1;
            end else begin
               r_pend      <= 1'b1;
               r_pend_line <= w_rf_line;
            end
         end else if (w_consume) begin
            r_pend <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               r_cnt  <= '0;
               r_widx <= '0;
               if (writeback_req) begin
                  r_state <= WB_LAT;
               end else if (r_pend) begin
                  r_state   <= RF_LAT;
                  r_rf_line <= r_pend_line;
               end else if (refill_req) begin
                  r_state   <= RF_LAT;
                  r_rf_line <= w_rf_line;
               end
            end
            WB_LAT: begin
               if (r_cnt == CNT_W'(MEM_LATENCY - 1)) r_state <= WB_WRITE;
               else                                  r_cnt   <= r_cnt + 1'b1;
            end
            WB_WRITE: begin
               r_widx <= r_widx + 1'b1;
               if (r_widx == WIDX_W'(WORDS_PER_LINE - 1)) r_state <= WB_DONE;
            end
            WB_DONE: begin
               r_done  <= 1'b1;
               r_state <= WB_RELEASE;
            end
            WB_RELEASE: begin
               if (!writeback_req) r_state <= IDLE;
            end
            RF_LAT: begin
               if (r_cnt == CNT_W'(MEM_LATENCY - 1)) r_state <= RF_STREAM;
               else                                  r_cnt   <= r_cnt + 1'b1;
            end
            RF_STREAM: begin
               r_valid <= 1'b1;
               r_data  <= r_mem[{r_rf_line, r_widx}];
               r_widx  <= r_widx + 1'b1;
               if (r_widx == WIDX_W'(WORDS_PER_LINE - 1)) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Line buffer and backing store carry no reset; an aborted write-back keeps
   // whatever words it already committed.
   always_ff @(posedge clk) begin
      if (r_state == IDLE && writeback_req) begin
         r_wb_line <= w_wb_line;
         r_wb_buf  <= writeback_data;
      end
      if (r_state == WB_WRITE)
         r_mem[{r_wb_line, r_widx}] <= r_wb_buf[r_widx*DATA_LENGTH +: DATA_LENGTH];
   end

endmodule
